// File: rtl/msx_audio_mixer_pkg.sv
// Shared types and constants for the MSX audio mixing path.
// The gain fixed-point position is derived from the unity code so both stay consistent.
package msx_audio_mixer_pkg;

  typedef enum logic [1:0] {
    MIX_IDLE = 2'd0,
    MIX_ACC  = 2'd1,
    MIX_SAT  = 2'd2
  } mixer_state_t;

  localparam logic [3:0]  MIX_GAIN_UNITY = 4'd8;
  localparam int unsigned MIX_GAIN_SHIFT = $clog2(MIX_GAIN_UNITY);

endpackage

// File: rtl/msx_audio_sat.sv
// Combinational arithmetic right shift followed by signed saturation to OUT_W bits.
// Requires ACC_W >= OUT_W; clip flags any value that had to be limited.
module msx_audio_sat #(
  parameter int ACC_W     = 22,
  parameter int OUT_W     = 16,
  parameter int OUT_SHIFT = 0
) (
  input  logic signed [ACC_W-1:0] acc,
  output logic signed [OUT_W-1:0] sat_value,
  output logic                    sat_clip
);

  localparam logic signed [ACC_W-1:0] SAT_MAX = {{(ACC_W-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] SAT_MIN = {{(ACC_W-OUT_W+1){1'b1}}, {(OUT_W-1){1'b0}}};

  logic signed [ACC_W-1:0] shifted_s;

  assign shifted_s = acc >>> OUT_SHIFT;

  // Clamp the shifted sum into the signed output range
  always_comb begin
    sat_value = shifted_s[OUT_W-1:0];
    sat_clip  = 1'b0;
    if (shifted_s > SAT_MAX) begin
      sat_value = SAT_MAX[OUT_W-1:0];
      sat_clip  = 1'b1;
    end else if (shifted_s < SAT_MIN) begin
      sat_value = SAT_MIN[OUT_W-1:0];
      sat_clip  = 1'b1;
    end else begin
      sat_value = shifted_s[OUT_W-1:0];
      sat_clip  = 1'b0;
    end
  end

endmodule

// File: rtl/msx_audio_mixer.sv
// N-channel gain/mute sample mixer: one channel MAC per clock, saturated output with valid pulse.
// Optional peak meter and sticky clip flag are built when MIXER_PEAK_EN is defined.
module msx_audio_mixer
  import msx_audio_mixer_pkg::*;
#(
  parameter int NUM_CH    = 8,
  parameter int IN_W      = 16,
  parameter int OUT_W     = 16,
  parameter int OUT_SHIFT = 0
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   sample_ce,
  input  logic [NUM_CH*IN_W-1:0] ch_in,
  input  logic [NUM_CH*4-1:0]    ch_gain,
  input  logic [NUM_CH-1:0]      ch_mute,
  output logic [OUT_W-1:0]       audio_out,
  output logic                   audio_valid,
  output logic                   clip,
  output logic                   busy,
  output logic                   overrun,
  output logic [OUT_W-2:0]       peak_out,
  output logic                   clip_sticky,
  input  logic                   peak_clear
);

  localparam int ACC_W  = IN_W + 2 + $clog2(NUM_CH) + 1;
  localparam int IDX_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int PROD_W = IN_W + 5;
  localparam int TERM_W = PROD_W - int'(MIX_GAIN_SHIFT);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_CH - 1);

  mixer_state_t state_r;
  mixer_state_t state_s;

  logic [IDX_W-1:0]       idx_r;
  logic [NUM_CH*IN_W-1:0] ch_sh_r;
  logic [NUM_CH*4-1:0]    gain_sh_r;
  logic [NUM_CH-1:0]      mute_sh_r;
  logic signed [ACC_W-1:0] acc_r;

  logic [OUT_W-1:0] audio_out_r;
  logic             audio_valid_r;
  logic             clip_r;
  logic             busy_r;
  logic             overrun_r;

  logic signed [IN_W-1:0]   ch_sel_s;
  logic signed [4:0]        gain_sel_s;
  logic                     mute_sel_s;
  logic signed [PROD_W-1:0] prod_s;
  logic signed [TERM_W-1:0] term_s;
  logic signed [ACC_W-1:0]  term_ext_s;
  logic signed [ACC_W-1:0]  acc_sum_s;
  logic signed [OUT_W-1:0]  sat_value_s;
  logic                     sat_clip_s;

  assign ch_sel_s   = ch_sh_r[idx_r*IN_W +: IN_W];
  assign gain_sel_s = {1'b0, gain_sh_r[idx_r*4 +: 4]};
  assign mute_sel_s = mute_sh_r[idx_r];
  assign prod_s     = PROD_W'(ch_sel_s) * PROD_W'(gain_sel_s);

  // Gain-scaled contribution of the current channel; dropping the low bits floors toward -inf
  always_comb begin
    term_s = '0;
    if (mute_sel_s) begin
      term_s = '0;
    end else begin
      term_s = prod_s[PROD_W-1:int'(MIX_GAIN_SHIFT)];
    end
  end

  assign term_ext_s = {{(ACC_W-TERM_W){term_s[TERM_W-1]}}, term_s};
  assign acc_sum_s  = acc_r + term_ext_s;

  // The final sum is saturated as the last channel is added, so the result is already
  // registered and visible while the FSM sits in MIX_SAT.
  msx_audio_sat #(
    .ACC_W    (ACC_W),
    .OUT_W    (OUT_W),
    .OUT_SHIFT(OUT_SHIFT)
  ) u_sat (
    .acc      (acc_sum_s),
    .sat_value(sat_value_s),
    .sat_clip (sat_clip_s)
  );

  // Next-state decode for the mix sequencer
  always_comb begin
    state_s = state_r;
    case (state_r)
      MIX_IDLE: begin
        if (sample_ce) state_s = MIX_ACC;
        else           state_s = MIX_IDLE;
      end
      MIX_ACC: begin
        if (idx_r == LAST_IDX) state_s = MIX_SAT;
        else                   state_s = MIX_ACC;
      end
      MIX_SAT: state_s = MIX_IDLE;
      default: state_s = MIX_IDLE;
    endcase
  end

  // Sequencer state, shadow capture, accumulation and registered outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r       <= MIX_IDLE;
      idx_r         <= '0;
      acc_r         <= '0;
      ch_sh_r       <= '0;
      gain_sh_r     <= '0;
      mute_sh_r     <= '0;
      audio_out_r   <= '0;
      audio_valid_r <= 1'b0;
      clip_r        <= 1'b0;
      busy_r        <= 1'b0;
      overrun_r     <= 1'b0;
    end else begin
      state_r       <= state_s;
      busy_r        <= (state_s != MIX_IDLE);
      overrun_r     <= sample_ce && (state_r != MIX_IDLE);
      audio_valid_r <= 1'b0;
      clip_r        <= 1'b0;
      case (state_r)
        MIX_IDLE: begin
          if (sample_ce) begin
            ch_sh_r   <= ch_in;
            gain_sh_r <= ch_gain;
            mute_sh_r <= ch_mute;
            acc_r     <= '0;
            idx_r     <= '0;
          end
        end
        MIX_ACC: begin
          acc_r <= acc_sum_s;
          idx_r <= idx_r + IDX_W'(1);
          if (idx_r == LAST_IDX) begin
            audio_out_r   <= sat_value_s;
            audio_valid_r <= 1'b1;
            clip_r        <= sat_clip_s;
          end
        end
        default: begin
          idx_r <= idx_r;
        end
      endcase
    end
  end

  assign audio_out   = audio_out_r;
  assign audio_valid = audio_valid_r;
  assign clip        = clip_r;
  assign busy        = busy_r;
  assign overrun     = overrun_r;

`ifdef MIXER_PEAK_EN
  logic [OUT_W-2:0] peak_r;
  logic [OUT_W-2:0] mag_s;
  logic             clip_sticky_r;

  // Magnitude of the published sample; the most negative code maps to full scale
  always_comb begin
    mag_s = audio_out_r[OUT_W-2:0];
    if (audio_out_r[OUT_W-1] && (audio_out_r[OUT_W-2:0] == '0)) begin
      mag_s = '1;
    end else if (audio_out_r[OUT_W-1]) begin
      mag_s = ~audio_out_r[OUT_W-2:0] + (OUT_W-1)'(1);
    end else begin
      mag_s = audio_out_r[OUT_W-2:0];
    end
  end

  // Peak hold and sticky clip; a clear request wins over a same-cycle update
  always_ff @(posedge clk) begin
    if (reset) begin
      peak_r        <= '0;
      clip_sticky_r <= 1'b0;
    end else if (peak_clear) begin
      peak_r        <= '0;
      clip_sticky_r <= 1'b0;
    end else if (audio_valid_r) begin
      if (mag_s > peak_r) peak_r <= mag_s;
      clip_sticky_r <= clip_sticky_r | clip_r;
    end
  end

  assign peak_out    = peak_r;
  assign clip_sticky = clip_sticky_r;
`else
  logic unused_peak_clear_s;

  assign unused_peak_clear_s = peak_clear;
  assign peak_out            = '0;
  assign clip_sticky         = 1'b0;
`endif

endmodule
